// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state encoding, strobe levels and request layout for the
// 8-bit MMIO bus master.
package mmio_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

   localparam logic STRB_ON  = 1'b0;
   localparam logic STRB_OFF = 1'b1;

   localparam int DATA_W = 32;
   localparam int LANES  = DATA_W / 8;

   // Size field carries byte count minus one: 0 -> 1 byte ... 3 -> 4 bytes.
   typedef logic [1:0] size_t;

   typedef struct packed {
      logic              we;
      size_t             size;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic [2:0] byte_count(input size_t size);
      return {1'b0, size} + 3'd1;
   endfunction

endpackage

// File: rtl/mmio_wait_ctr.sv
// mmio_wait_ctr: loadable down-counter; 'last' flags the final strobe cycle.
module mmio_wait_ctr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         last
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     cnt_q <= '0;
      else if (load)               cnt_q <= load_val;
      else if (dec && cnt_q != '0) cnt_q <= cnt_q - W'(1);
   end

   assign last = (cnt_q == '0);

endmodule

// File: rtl/mmio_bus_master.sv
// mmio_bus_master: sequences 1-4 byte little-endian CPU requests onto the 8-bit
// MMIO bus. Define MMIO_POSTED_WRITE_EN to acknowledge writes at acceptance.
module mmio_bus_master
   import mmio_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   inout  wire  [7:0]        bus_data,
   output logic              bus_cs_,
   output logic              bus_oe_,
   output logic              bus_we_
);

   localparam int WS_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

   state_t            state_q, state_d;
   req_t              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        idx_q;
   logic [31:0]       rbuf_q, rbuf_d, rdata_q;
   logic              accept, strb_last, last_byte, capture, drive;
   logic [7:0]        wbyte;

   assign accept    = req_valid && req_ready;
   assign last_byte = ({1'b0, idx_q} + 3'd1) == byte_count(req_q.size);
   assign capture   = (state_q == STROBE) && strb_last && !req_q.we;

   mmio_wait_ctr #(.W(WS_W)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q == SETUP),
      .load_val (WS_W'(WAIT_STATES)),
      .dec      (state_q == STROBE),
      .last     (strb_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = STROBE;
         STROBE:  if (strb_last) state_d = last_byte ? DONE : SETUP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes and the data driver decode straight from state so that reset
   // releases the bus without waiting for a clock edge.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      bus_cs_   = STRB_OFF;
      bus_oe_   = STRB_OFF;
      bus_we_   = STRB_OFF;
      bus_addr  = '0;
      drive     = 1'b0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         SETUP: begin
            bus_cs_  = STRB_ON;
            bus_addr = addr_q + ADDR_W'(idx_q);
            drive    = req_q.we;
`ifdef MMIO_POSTED_WRITE_EN
            rsp_valid = req_q.we && (idx_q == 2'd0);
`endif
         end
         STROBE: begin
            bus_cs_  = STRB_ON;
            bus_addr = addr_q + ADDR_W'(idx_q);
            drive    = req_q.we;
            if (req_q.we) bus_we_ = STRB_ON;
            else          bus_oe_ = STRB_ON;
         end
         DONE: begin
`ifdef MMIO_POSTED_WRITE_EN
            rsp_valid = !req_q.we;
`else
            rsp_valid = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   assign wbyte    = req_q.wdata[{idx_q, 3'b000} +: 8];
   assign bus_data = drive ? wbyte : 8'hzz;

   always_comb begin
      rbuf_d = rbuf_q;
      if (capture) rbuf_d[{idx_q, 3'b000} +: 8] = bus_data;
   end

   // rdata_q only moves when a read completes; the working buffer starts at
   // zero so lanes beyond the request size read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         req_q   <= '{we: req_we, size: req_size, wdata: req_wdata};
         addr_q  <= req_addr;
         idx_q   <= '0;
         rbuf_q  <= '0;
      end else begin
         rbuf_q <= rbuf_d;
         if (state_q == STROBE && strb_last) idx_q <= idx_q + 2'd1;
         if (capture && last_byte)           rdata_q <= rbuf_d;
      end
   end

   assign rsp_rdata = (rsp_valid && req_q.we) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_mmio_bus_master.sv
// tb_mmio_bus_master: two masters (WAIT_STATES 0 and 2) on byte-memory
// peripherals; expected responses and bus accesses are queued and checked.
module tb_mmio_bus_master;

   localparam int NDUT = 2;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } bus_acc_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_valid [NDUT];
   logic        req_ready [NDUT];
   logic        req_we    [NDUT];
   logic [7:0]  req_addr  [NDUT];
   logic [1:0]  req_size  [NDUT];
   logic [31:0] req_wdata [NDUT];
   logic        rsp_valid [NDUT];
   logic [31:0] rsp_rdata [NDUT];
   logic [7:0]  bus_addr  [NDUT];
   logic        bus_cs_   [NDUT];
   logic        bus_oe_   [NDUT];
   logic        bus_we_   [NDUT];
   logic [7:0]  bd_s      [NDUT];
   logic [7:0]  mem       [NDUT][256];

   rsp_exp_t exp_q [NDUT][$];
   bus_acc_t bus_q [NDUT][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A released bus reads as Z, or as 0 in two-state simulation.
   task automatic chk_rel(input string name, input logic [7:0] act);
      checks++;
      if (!(act === 8'hzz || act === 8'h00)) begin
         errors++;
         $display("FAIL %s: bus_data %h while master should be released (t=%0t)", name, act, $time);
      end
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int WS = 2 * g;
      wire [7:0] bd;
      logic      prev_strb = 1'b0;
      int        strb_len  = 0;
      int        acc_cyc   = 0;

      mmio_bus_master #(.ADDR_W(8), .WAIT_STATES(WS)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_size  (req_size[g]),
         .req_wdata (req_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .bus_addr  (bus_addr[g]),
         .bus_data  (bd),
         .bus_cs_   (bus_cs_[g]),
         .bus_oe_   (bus_oe_[g]),
         .bus_we_   (bus_we_[g])
      );

      assign bd      = (!bus_cs_[g] && !bus_oe_[g]) ? mem[g][bus_addr[g]] : 8'hzz;
      assign bd_s[g] = bd;

      always @(posedge clk)
         if (!bus_cs_[g] && !bus_we_[g]) mem[g][bus_addr[g]] <= bd;

      always @(negedge clk) begin : mon
         rsp_exp_t e;
         bus_acc_t b;
         logic     strb;
         strb = !bus_oe_[g] || !bus_we_[g];
         if (rst) begin
            prev_strb = 1'b0;
            strb_len  = 0;
         end else begin
            if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
            if (rsp_valid[g]) begin
               if (exp_q[g].size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
               else begin
                  e = exp_q[g].pop_front();
                  chk("rsp_rdata", rsp_rdata[g], e.rdata);
                  chk("rsp_latency", cyc - acc_cyc, e.lat);
               end
            end
            if (!bus_oe_[g] && !bus_we_[g]) chk("strobe_contention", 32'd1, 32'd0);
            if (bus_cs_[g]) chk_rel("idle_release", bd);
            else if (!strb) begin
               if (bus_q[g].size() == 0 || !bus_q[g][0].we) chk_rel("read_setup_release", bd);
               else chk("setup_wdata", bd, bus_q[g][0].data);
            end
            if (strb && !prev_strb) begin
               if (bus_q[g].size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
               else begin
                  b = bus_q[g].pop_front();
                  chk("bus_addr", bus_addr[g], b.addr);
                  chk("bus_dir_we", !bus_we_[g], b.we);
                  chk("bus_data", bd, b.data);
                  chk("bus_cs_low", bus_cs_[g], 1'b0);
               end
            end
            if (strb) strb_len++;
            else if (prev_strb) begin
               chk("strobe_len", strb_len, WS + 1);
               strb_len = 0;
            end
            prev_strb = strb;
         end
      end
   end

   task automatic issue(input int d, input logic we, input logic [7:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
      rsp_exp_t e;
      bus_acc_t b;
      int k;
      e.rdata = we ? 32'h0 : rdata;
      e.lat   = lat;
`ifdef MMIO_POSTED_WRITE_EN
      if (we) e.lat = 1;
`endif
      exp_q[d].push_back(e);
      for (int i = 0; i <= int'(size); i++) begin
         b.we   = we;
         b.addr = addr + 8'(i);
         b.data = we ? wdata[8*i +: 8] : rdata[8*i +: 8];
         bus_q[d].push_back(b);
      end
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_size[d]  = size;
      req_wdata[d] = wdata;
      k = 0;
      while (!req_ready[d] && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("accept_timeout", k < 50, 1'b1);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int k;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!(req_ready[d] && exp_q[d].size() == 0) && k < 200);
      chk("done_timeout", k < 200, 1'b1);
      chk("bus_q_drained", bus_q[d].size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = 8'h00;
         req_size[d]  = 2'd0;
         req_wdata[d] = 32'h0;
         for (int a = 0; a < 256; a++) mem[d][a] <= 8'h00;
      end
      #1;
      mem[0][8'h00] <= 8'hFE;
      mem[0][8'hFF] <= 8'h3C;
      mem[0][8'h23] <= 8'h77;
      mem[1][8'h30] <= 8'h2D;
      mem[1][8'h31] <= 8'h4B;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk("rst_req_ready", req_ready[d], 1'b1);
         chk("rst_rsp_valid", rsp_valid[d], 1'b0);
         chk("rst_rsp_rdata", rsp_rdata[d], 32'h0);
         chk("rst_cs", bus_cs_[d], 1'b1);
         chk("rst_oe", bus_oe_[d], 1'b1);
         chk("rst_we", bus_we_[d], 1'b1);
         chk("rst_addr", bus_addr[d], 8'h00);
         chk_rel("rst_bus_release", bd_s[d]);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // timer compare register write, then read back
      issue(0, 1'b1, 8'h04, 2'd3, 32'h00000010, 32'h0, 9);
      wait_done(0);
      chk("compare_reg", {mem[0][7], mem[0][6], mem[0][5], mem[0][4]}, 32'h00000010);
      issue(0, 1'b0, 8'h04, 2'd3, 32'hDEADBEEF, 32'h00000010, 9);
      wait_done(0);
      // counter read
      issue(0, 1'b0, 8'h00, 2'd3, 32'hDEADBEEF, 32'h000000FE, 9);
      wait_done(0);
      // address wrap 0xFF -> 0x00
      issue(0, 1'b0, 8'hFF, 2'd1, 32'hDEADBEEF, 32'h0000FE3C, 5);
      wait_done(0);
      // 3-byte write leaves the fourth byte alone; rdata holds across a write
      issue(0, 1'b1, 8'h20, 2'd2, 32'hAAC0FFEE, 32'h0, 7);
      wait_done(0);
      chk("rdata_held", rsp_rdata[0], 32'h0000FE3C);
      chk("untouched_byte", mem[0][8'h23], 8'h77);
      issue(0, 1'b0, 8'h20, 2'd3, 32'hDEADBEEF, 32'h77C0FFEE, 9);
      wait_done(0);
      issue(0, 1'b0, 8'h21, 2'd0, 32'hDEADBEEF, 32'h000000FF, 3);
      wait_done(0);

      // reset during the strobe of byte 2 of a read
      issue(0, 1'b0, 8'h00, 2'd3, 32'hDEADBEEF, 32'h000000FE, 9);
      k = 0;
      while (!(bus_addr[0] == 8'h02 && !bus_oe_[0]) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_byte2_strobe", k < 50, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("abort_cs", bus_cs_[0], 1'b1);
      chk("abort_oe", bus_oe_[0], 1'b1);
      chk("abort_rsp_valid", rsp_valid[0], 1'b0);
      chk_rel("abort_bus_release", bd_s[0]);
      exp_q[0].delete();
      bus_q[0].delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_req_ready", req_ready[0], 1'b1);
      repeat (12) @(posedge clk);
      #1;

      // WAIT_STATES=2: 1-byte write with a request pulse mid-transfer
      issue(1, 1'b1, 8'h10, 2'd0, 32'h000000A5, 32'h0, 5);
      @(posedge clk); #1;
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 8'h50;
      chk("busy_not_ready", req_ready[1], 1'b0);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_done(1);
      repeat (10) @(posedge clk);
      #1;
      chk("ws2_write_mem", mem[1][8'h10], 8'hA5);
      issue(1, 1'b0, 8'h30, 2'd1, 32'hDEADBEEF, 32'h00004B2D, 9);
      wait_done(1);
      repeat (4) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
